regfile_access_ctrl: RTL and testbench

//   Initiator-side controller for the 32-bit 1-write/2-read posedge register-file SRAM (SRAM32XN1W2RCPBW).
//   - Converts a valid/ready two-operand read request into active-low SRAM read strobes.
//   - Converts a writeback stream into active-low SRAM write strobes.
//   - Buffers the 1-cycle SRAM read latency in a 1-entry response stage.
//   - Enforces the zero register; optionally forwards same-address writes.

---
 rtl/regfile_access_ctrl.sv | 154 +++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl.sv
// Initiator-side controller for a 1-write/2-read posedge register-file SRAM with a 1-entry response stage.
// Optional feature macro RF_WB_BYPASS_EN: forwards same-address writebacks into the response data.
module regfile_access_ctrl #(
    parameter int WORD_COUNT = 32,
    parameter int ZERO_REG   = 1,
    localparam int AW = $clog2(WORD_COUNT)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          REQ_VALID,
    output logic          REQ_READY,
    input  logic [AW-1:0] REQ_RS1,
    input  logic [AW-1:0] REQ_RS2,
    output logic          RSP_VALID,
    input  logic          RSP_READY,
    output logic [31:0]   RSP_D1,
    output logic [31:0]   RSP_D2,
    input  logic          WB_VALID,
    input  logic [AW-1:0] WB_ADDR,
    input  logic [31:0]   WB_DATA,
    input  logic [31:0]   WB_MASK,
    output logic          SRAM_WEC,
    output logic [31:0]   SRAM_BWC,
    output logic [31:0]   SRAM_DC,
    output logic [AW-1:0] SRAM_AC,
    output logic          SRAM_REA,
    output logic [AW-1:0] SRAM_AA,
    input  logic [31:0]   SRAM_QA,
    output logic          SRAM_REB,
    output logic [AW-1:0] SRAM_AB,
    input  logic [31:0]   SRAM_QB
);

    logic          rsp_valid_reg;
    logic          fresh_reg;      // response accepted last cycle: data is taken live from SRAM Q
    logic          accept;
    logic          wb_en;
    logic [AW-1:0] req_rs [2];
    logic [31:0]   sram_q [2];
    logic [31:0]   rsp_d  [2];

    assign req_rs[0] = REQ_RS1;
    assign req_rs[1] = REQ_RS2;
    assign sram_q[0] = SRAM_QA;
    assign sram_q[1] = SRAM_QB;

    assign wb_en     = WB_VALID & ~RESET & ~((ZERO_REG != 0) && (WB_ADDR == '0));
    assign REQ_READY = ~RESET & (~rsp_valid_reg | RSP_READY);
    assign accept    = REQ_VALID & REQ_READY;
    assign RSP_VALID = rsp_valid_reg & ~RESET;
    assign RSP_D1    = rsp_d[0];
    assign RSP_D2    = rsp_d[1];

    assign SRAM_WEC  = ~wb_en;
    assign SRAM_AC   = WB_ADDR;
    assign SRAM_DC   = WB_DATA;
    assign SRAM_BWC  = WB_MASK;
    assign SRAM_REA  = ~accept;
    assign SRAM_REB  = ~accept;
    assign SRAM_AA   = REQ_RS1;
    assign SRAM_AB   = REQ_RS2;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rsp_valid_reg <= 1'b0;
            fresh_reg     <= 1'b0;
        end else if (accept) begin
            rsp_valid_reg <= 1'b1;
            fresh_reg     <= 1'b1;
        end else begin
            fresh_reg <= 1'b0;
            if (RSP_READY) begin
                rsp_valid_reg <= 1'b0;
            end
        end
    end

`ifdef RF_WB_BYPASS_EN
    logic        stall;
    logic [31:0] byp_data_reg;
    logic [31:0] byp_mask_reg;

    assign stall = rsp_valid_reg & ~RSP_READY;

    // The SRAM returns pre-write data, so an accept-cycle write is kept here and merged at T+1.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            byp_data_reg <= '0;
            byp_mask_reg <= '0;
        end else if (accept && wb_en) begin
            byp_data_reg <= WB_DATA;
            byp_mask_reg <= WB_MASK;
        end
    end
`endif

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
            logic        is_zero_reg;
            logic [31:0] hold_reg;
            logic [31:0] hold_next;
            logic [31:0] fresh_d;
            logic [31:0] cur_d;
`ifdef RF_WB_BYPASS_EN
            logic          hit_reg;
            logic [AW-1:0] addr_reg;
`endif

            always_comb begin
                fresh_d = sram_q[gi];
`ifdef RF_WB_BYPASS_EN
                if (hit_reg) begin
                    fresh_d = (byp_data_reg & byp_mask_reg) | (sram_q[gi] & ~byp_mask_reg);
                end
`endif
                if (is_zero_reg) begin
                    fresh_d = '0;
                end
                cur_d     = fresh_reg ? fresh_d : hold_reg;
                hold_next = cur_d;
`ifdef RF_WB_BYPASS_EN
                if (stall && wb_en && (WB_ADDR == addr_reg)) begin
                    hold_next = (WB_DATA & WB_MASK) | (cur_d & ~WB_MASK);
                end
`endif
            end

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    is_zero_reg <= 1'b0;
                    hold_reg    <= '0;
`ifdef RF_WB_BYPASS_EN
                    hit_reg     <= 1'b0;
                    addr_reg    <= '0;
`endif
                end else begin
                    if (accept) begin
                        is_zero_reg <= (ZERO_REG != 0) && (req_rs[gi] == '0);
`ifdef RF_WB_BYPASS_EN
                        hit_reg     <= wb_en && (WB_ADDR == req_rs[gi]);
                        addr_reg    <= req_rs[gi];
`endif
                    end
                    if (rsp_valid_reg) begin
                        hold_reg <= hold_next;
                    end
                end
            end

            assign rsp_d[gi] = RESET ? '0 : cur_d;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed testbench for regfile_access_ctrl with a behavioural 1W2R SRAM model and a reference array.
module tb_regfile_access_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        REQ_VALID, REQ_READY;
    logic [4:0]  REQ_RS1, REQ_RS2;
    logic        RSP_VALID, RSP_READY;
    logic [31:0] RSP_D1, RSP_D2;
    logic        WB_VALID;
    logic [4:0]  WB_ADDR;
    logic [31:0] WB_DATA, WB_MASK;
    logic        SRAM_WEC, SRAM_REA, SRAM_REB;
    logic [31:0] SRAM_BWC, SRAM_DC, SRAM_QA, SRAM_QB;
    logic [4:0]  SRAM_AC, SRAM_AA, SRAM_AB;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] ref_mem [32];
    logic [31:0] sram_mem [32];

`ifdef RF_WB_BYPASS_EN
    localparam logic [31:0] EXP_SAME = 32'h0000_1234;
    localparam logic [31:0] EXP_HELD = 32'hAAAA_2222;
`else
    localparam logic [31:0] EXP_SAME = 32'h0000_0055;
    localparam logic [31:0] EXP_HELD = 32'h1111_2222;
`endif

    regfile_access_ctrl dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_RS1(REQ_RS1), .REQ_RS2(REQ_RS2),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_D1(RSP_D1), .RSP_D2(RSP_D2),
        .WB_VALID(WB_VALID), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA), .WB_MASK(WB_MASK),
        .SRAM_WEC(SRAM_WEC), .SRAM_BWC(SRAM_BWC), .SRAM_DC(SRAM_DC), .SRAM_AC(SRAM_AC),
        .SRAM_REA(SRAM_REA), .SRAM_AA(SRAM_AA), .SRAM_QA(SRAM_QA),
        .SRAM_REB(SRAM_REB), .SRAM_AB(SRAM_AB), .SRAM_QB(SRAM_QB)
    );

    always #5 CLK = ~CLK;

    // SRAM model: read-before-write; x0 holds garbage so the zero-register masking is observable.
    always @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 32; i++) sram_mem[i] <= (i == 0) ? 32'hBAD0_BAD0 : 32'h0;
        end else if (!SRAM_WEC) begin
            sram_mem[SRAM_AC] <= (sram_mem[SRAM_AC] & ~SRAM_BWC) | (SRAM_DC & SRAM_BWC);
        end
        if (!SRAM_REA) SRAM_QA <= sram_mem[SRAM_AA];
        if (!SRAM_REB) SRAM_QB <= sram_mem[SRAM_AB];
    end

    function automatic logic [31:0] exp_val(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : ref_mem[a];
    endfunction

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [31:0] m);
        @(negedge CLK);
        WB_VALID = 1'b1; WB_ADDR = a; WB_DATA = d; WB_MASK = m; REQ_VALID = 1'b0;
        if (a != 5'd0) ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
        #1;
    endtask

    // Issues one read with RSP_READY=1 and returns what the response cycle shows.
    task automatic do_read(input logic [4:0] a1, input logic [4:0] a2, output logic v,
                           output logic [31:0] d1, output logic [31:0] d2, output logic [1:0] re);
        @(negedge CLK);
        WB_VALID = 1'b0; REQ_VALID = 1'b1; REQ_RS1 = a1; REQ_RS2 = a2; RSP_READY = 1'b1;
        #1;
        re = {SRAM_REA, SRAM_REB};
        @(negedge CLK);
        REQ_VALID = 1'b0;
        #1;
        v = RSP_VALID; d1 = RSP_D1; d2 = RSP_D2;
    endtask

    task automatic test_reset();
        RESET = 1'b1; REQ_VALID = 1'b1; REQ_RS1 = 5'd1; REQ_RS2 = 5'd2; RSP_READY = 1'b1;
        WB_VALID = 1'b1; WB_ADDR = 5'd5; WB_DATA = 32'h1; WB_MASK = 32'hFFFF_FFFF;
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK); #1;
            vectors++;
            if ({REQ_READY, RSP_VALID, SRAM_WEC, SRAM_REA, SRAM_REB} !== 5'b00111) begin
                miscompares++;
                $display("FAIL reset_strobes cyc%0d: got rdy/vld/wec/rea/reb=%b want 00111", c,
                         {REQ_READY, RSP_VALID, SRAM_WEC, SRAM_REA, SRAM_REB});
            end
            vectors++;
            if ({RSP_D1, RSP_D2} !== 64'h0) begin
                miscompares++;
                $display("FAIL reset_data cyc%0d: got %h %h want 0 0", c, RSP_D1, RSP_D2);
            end
        end
        @(negedge CLK);
        RESET = 1'b0; REQ_VALID = 1'b0; WB_VALID = 1'b0;
        #1;
        vectors++;
        if (REQ_READY !== 1'b1 || RSP_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset: got rdy=%b vld=%b want 1 0", REQ_READY, RSP_VALID);
        end
    endtask

    task automatic test_write_read();
        logic v; logic [31:0] d1, d2; logic [1:0] re;
        do_write(5'd5, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        vectors++;
        if ({SRAM_WEC, SRAM_AC, SRAM_DC, SRAM_BWC} !== {1'b0, 5'd5, 32'hDEAD_BEEF, 32'hFFFF_FFFF}) begin
            miscompares++;
            $display("FAIL wr5_strobe: got wec=%b ac=%0d dc=%h bwc=%h want 0 5 deadbeef ffffffff",
                     SRAM_WEC, SRAM_AC, SRAM_DC, SRAM_BWC);
        end
        do_read(5'd5, 5'd0, v, d1, d2, re);
        vectors++;
        if (re !== 2'b00) begin
            miscompares++;
            $display("FAIL rd5_strobe: got rea/reb=%b want 00", re);
        end
        vectors++;
        if ({v, d1, d2} !== {1'b1, 32'hDEAD_BEEF, 32'h0}) begin
            miscompares++;
            $display("FAIL rd5_x0: got v=%b %h %h want 1 deadbeef 00000000", v, d1, d2);
        end
        vectors++;
        if ({SRAM_REA, SRAM_REB} !== 2'b11) begin
            miscompares++;
            $display("FAIL idle_strobe: got rea/reb=%b want 11", {SRAM_REA, SRAM_REB});
        end
    endtask

    task automatic test_masked_write();
        logic v; logic [31:0] d1, d2; logic [1:0] re;
        do_write(5'd7, 32'hFFFF_FFFF, 32'h0000_FF00);
        do_write(5'd7, 32'h0, 32'h0);
        vectors++;
        if (SRAM_WEC !== 1'b0) begin
            miscompares++;
            $display("FAIL mask0_wec: got %b want 0", SRAM_WEC);
        end
        do_read(5'd7, 5'd7, v, d1, d2, re);
        vectors++;
        if ({v, d1, d2} !== {1'b1, 32'h0000_FF00, 32'h0000_FF00}) begin
            miscompares++;
            $display("FAIL rd7_masked: got v=%b %h %h want 1 0000ff00 0000ff00", v, d1, d2);
        end
    endtask

    task automatic test_stall();
        @(negedge CLK);
        WB_VALID = 1'b0; REQ_VALID = 1'b1; REQ_RS1 = 5'd5; REQ_RS2 = 5'd7; RSP_READY = 1'b0;
        @(negedge CLK);
        REQ_RS1 = 5'd7; REQ_RS2 = 5'd5;
        for (int c = 0; c < 4; c++) begin
            #1;
            vectors++;
            if ({REQ_READY, RSP_VALID, RSP_D1, RSP_D2} !== {2'b01, 32'hDEAD_BEEF, 32'h0000_FF00}) begin
                miscompares++;
                $display("FAIL stall cyc%0d: got rdy=%b vld=%b %h %h want 0 1 deadbeef 0000ff00",
                         c, REQ_READY, RSP_VALID, RSP_D1, RSP_D2);
            end
            @(negedge CLK);
        end
        RSP_READY = 1'b1;
        #1;
        vectors++;
        if (REQ_READY !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release_rdy: got %b want 1", REQ_READY);
        end
        @(negedge CLK);
        REQ_VALID = 1'b0;
        #1;
        vectors++;
        if ({RSP_VALID, RSP_D1, RSP_D2} !== {1'b1, 32'h0000_FF00, 32'hDEAD_BEEF}) begin
            miscompares++;
            $display("FAIL queued_rsp: got v=%b %h %h want 1 0000ff00 deadbeef", RSP_VALID, RSP_D1, RSP_D2);
        end
        @(negedge CLK); #1;
        vectors++;
        if (RSP_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL queued_drop: got vld=%b want 0", RSP_VALID);
        end
    endtask

    task automatic test_bypass();
        logic v; logic [31:0] d1, d2; logic [1:0] re;
        do_write(5'd3, 32'h55, 32'hFFFF_FFFF);
        @(negedge CLK);
        WB_VALID = 1'b1; WB_ADDR = 5'd3; WB_DATA = 32'h1234; WB_MASK = 32'hFFFF_FFFF;
        REQ_VALID = 1'b1; REQ_RS1 = 5'd3; REQ_RS2 = 5'd3; RSP_READY = 1'b1;
        ref_mem[3] = 32'h1234;
        @(negedge CLK);
        WB_VALID = 1'b0; REQ_VALID = 1'b0;
        #1;
        vectors++;
        if ({RSP_VALID, RSP_D1, RSP_D2} !== {1'b1, EXP_SAME, EXP_SAME}) begin
            miscompares++;
            $display("FAIL same_cycle_wr_rd: got v=%b %h %h want 1 %h %h", RSP_VALID, RSP_D1, RSP_D2,
                     EXP_SAME, EXP_SAME);
        end
        do_read(5'd3, 5'd3, v, d1, d2, re);
        vectors++;
        if ({v, d1, d2} !== {1'b1, 32'h1234, 32'h1234}) begin
            miscompares++;
            $display("FAIL rd3_after: got v=%b %h %h want 1 00001234 00001234", v, d1, d2);
        end
        // A write landing while the response is held.
        do_write(5'd9, 32'h1111_2222, 32'hFFFF_FFFF);
        @(negedge CLK);
        WB_VALID = 1'b0; REQ_VALID = 1'b1; REQ_RS1 = 5'd9; REQ_RS2 = 5'd3; RSP_READY = 1'b0;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        WB_VALID = 1'b1; WB_ADDR = 5'd9; WB_DATA = 32'hAAAA_BBBB; WB_MASK = 32'hFFFF_0000;
        ref_mem[9] = 32'hAAAA_2222;
        #1;
        vectors++;
        if ({RSP_VALID, RSP_D1, RSP_D2} !== {1'b1, 32'h1111_2222, 32'h1234}) begin
            miscompares++;
            $display("FAIL held_pre: got v=%b %h %h want 1 11112222 00001234", RSP_VALID, RSP_D1, RSP_D2);
        end
        @(negedge CLK);
        WB_VALID = 1'b0;
        #1;
        vectors++;
        if ({RSP_VALID, RSP_D1, RSP_D2} !== {1'b1, EXP_HELD, 32'h1234}) begin
            miscompares++;
            $display("FAIL held_merge: got v=%b %h %h want 1 %h 00001234", RSP_VALID, RSP_D1, RSP_D2, EXP_HELD);
        end
        RSP_READY = 1'b1;
        do_read(5'd9, 5'd9, v, d1, d2, re);
        vectors++;
        if ({v, d1, d2} !== {1'b1, 32'hAAAA_2222, 32'hAAAA_2222}) begin
            miscompares++;
            $display("FAIL rd9_after: got v=%b %h %h want 1 aaaa2222 aaaa2222", v, d1, d2);
        end
    endtask

    task automatic test_zero_reg();
        logic v; logic [31:0] d1, d2; logic [1:0] re;
        do_write(5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        vectors++;
        if (SRAM_WEC !== 1'b1) begin
            miscompares++;
            $display("FAIL x0_wec: got %b want 1", SRAM_WEC);
        end
        do_read(5'd0, 5'd5, v, d1, d2, re);
        vectors++;
        if ({v, d1, d2} !== {1'b1, 32'h0, 32'hDEAD_BEEF}) begin
            miscompares++;
            $display("FAIL rd_x0: got v=%b %h %h want 1 00000000 deadbeef", v, d1, d2);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q1 [$];
        logic [31:0] q2 [$];
        logic [31:0] e1, e2;
        int acc = 0;
        int cyc = 0;
        for (int a = 1; a < 32; a++) do_write(5'(a), $urandom, 32'hFFFF_FFFF);
        @(negedge CLK);
        WB_VALID = 1'b0;
        while (acc < 100 && cyc < 3000) begin
            @(negedge CLK);
            REQ_VALID = ($urandom % 4) != 0;
            REQ_RS1 = 5'($urandom); REQ_RS2 = 5'($urandom);
            RSP_READY = ($urandom % 4) != 0;
            #1;
            if (RSP_VALID && RSP_READY) begin
                vectors++;
                if (q1.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_dup: got unexpected response %h %h want none", RSP_D1, RSP_D2);
                end else begin
                    e1 = q1.pop_front(); e2 = q2.pop_front();
                    if (RSP_D1 !== e1 || RSP_D2 !== e2) begin
                        miscompares++;
                        $display("FAIL sb_data: got %h %h want %h %h", RSP_D1, RSP_D2, e1, e2);
                    end
                end
            end
            if (REQ_VALID && REQ_READY) begin
                q1.push_back(exp_val(REQ_RS1));
                q2.push_back(exp_val(REQ_RS2));
                acc++;
            end
            cyc++;
        end
        @(negedge CLK);
        REQ_VALID = 1'b0; RSP_READY = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (RSP_VALID) begin
                vectors++;
                if (q1.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_drain_dup: got extra response %h %h want none", RSP_D1, RSP_D2);
                end else begin
                    e1 = q1.pop_front(); e2 = q2.pop_front();
                    if (RSP_D1 !== e1 || RSP_D2 !== e2) begin
                        miscompares++;
                        $display("FAIL sb_drain_data: got %h %h want %h %h", RSP_D1, RSP_D2, e1, e2);
                    end
                end
            end
            @(negedge CLK);
        end
        vectors++;
        if (acc != 100 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL sb_complete: got accepted=%0d outstanding=%0d want 100 0", acc, q1.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_masked_write();
        test_stall();
        test_bypass();
        test_zero_reg();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
